// File: rtl/alarm_pkg.sv
// +----------------------------------------------------------------------+
// | alarm_pkg : shared state encoding and delay-counter width for alarm_ctrl |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package alarm_pkg;

  localparam int c_cnt_w = 8;

  typedef enum logic [2:0] {
    ST_DISARMED = 3'd0,
    ST_EXIT     = 3'd1,
    ST_ARMED    = 3'd2,
    ST_ENTRY    = 3'd3,
    ST_ALARM    = 3'd4
  } state_t;

  function automatic logic is_armed(input state_t s);
    return (s == ST_EXIT) || (s == ST_ARMED) || (s == ST_ENTRY) || (s == ST_ALARM);
  endfunction

  // States in which active zones are accumulated into the tripped record
  function automatic logic is_watching(input state_t s);
    return (s == ST_ARMED) || (s == ST_ENTRY) || (s == ST_ALARM);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alarm_dly_cnt.sv
// +----------------------------------------------------------------------+
// | alarm_dly_cnt : loadable down-counter, saturates at zero             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module alarm_dly_cnt
  import alarm_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic [c_cnt_w-1:0] i_value,
  input  logic               i_dec,
  output logic [c_cnt_w-1:0] o_value,
  output logic               o_zero
);

  logic [c_cnt_w-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - c_cnt_w'(1);
    end
  end

  assign o_value = r_cnt;
  assign o_zero  = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/alarm_ctrl.sv
// +----------------------------------------------------------------------+
// | alarm_ctrl : multi-zone intruder alarm with exit/entry delays        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int                 N_ZONES      = 4,
  parameter int                 ENTRY_DLY    = 8,
  parameter int                 EXIT_DLY     = 8,
  parameter logic [N_ZONES-1:0] INSTANT_MASK = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_ZONES-1:0] sen,
  input  logic [N_ZONES-1:0] zone_en,
  input  logic               arm,
  input  logic               disarm,
  output logic               armed,
  output logic               alarm_out,
  output logic [N_ZONES-1:0] tripped,
  output logic [2:0]         state
);

  localparam logic [c_cnt_w-1:0] c_entry_ld = c_cnt_w'(ENTRY_DLY);
  localparam logic [c_cnt_w-1:0] c_exit_ld  = c_cnt_w'(EXIT_DLY);

  state_t             r_state;
  state_t             w_next;
  logic [N_ZONES-1:0] r_sen_q;
  logic [N_ZONES-1:0] r_tripped;
  logic [N_ZONES-1:0] w_active;
  logic               w_inst_hit;
  logic               w_any_hit;
  logic               w_clr_trip;
  logic               w_cnt_load;
  logic [c_cnt_w-1:0] w_cnt_ld_val;
  logic               w_cnt_dec;
  logic [c_cnt_w-1:0] w_cnt_val;
  logic               w_cnt_zero;
  logic               w_last;

  assign w_active   = r_sen_q & zone_en;
  assign w_inst_hit = |(w_active & INSTANT_MASK);
  assign w_any_hit  = |w_active;
  // Counter is loaded with the full delay, so the phase ends on the edge where it holds 1
  assign w_last     = w_cnt_zero || (w_cnt_val == c_cnt_w'(1));

  alarm_dly_cnt u_dly_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_cnt_load),
    .i_value (w_cnt_ld_val),
    .i_dec   (w_cnt_dec),
    .o_value (w_cnt_val),
    .o_zero  (w_cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_DISARMED;
      r_sen_q   <= '0;
      r_tripped <= '0;
    end else begin
      r_state <= w_next;
      r_sen_q <= sen;
      if (w_clr_trip) begin
        r_tripped <= '0;
      end else if (is_watching(r_state)) begin
        r_tripped <= r_tripped | w_active;
      end
    end
  end

  always_comb begin
    w_next       = r_state;
    w_cnt_load   = 1'b0;
    w_cnt_ld_val = '0;
    w_cnt_dec    = 1'b0;
    w_clr_trip   = 1'b0;
    if (disarm && (r_state != ST_DISARMED)) begin
      w_next     = ST_DISARMED;
      w_cnt_load = 1'b1;
    end else begin
      unique case (r_state)
        ST_DISARMED: begin
          if (arm && !disarm) begin
            w_clr_trip   = 1'b1;
            w_cnt_load   = 1'b1;
            w_cnt_ld_val = c_exit_ld;
            w_next       = (EXIT_DLY == 0) ? ST_ARMED : ST_EXIT;
          end
        end
        ST_EXIT: begin
          w_cnt_dec = 1'b1;
          if (w_last) w_next = ST_ARMED;
        end
        ST_ARMED: begin
          if (w_inst_hit) begin
            w_next = ST_ALARM;
          end else if (w_any_hit) begin
            w_cnt_load   = 1'b1;
            w_cnt_ld_val = c_entry_ld;
            w_next       = (ENTRY_DLY == 0) ? ST_ALARM : ST_ENTRY;
          end
        end
        ST_ENTRY: begin
          w_cnt_dec = 1'b1;
          if (w_inst_hit || w_last) w_next = ST_ALARM;
        end
        ST_ALARM: begin
          w_next = ST_ALARM;
        end
        default: begin
          w_next     = ST_DISARMED;
          w_cnt_load = 1'b1;
        end
      endcase
    end
  end

  // Decoded from the state register only, so rst clears them without a clock edge
  assign armed     = is_armed(r_state);
  assign alarm_out = (r_state == ST_ALARM);
  assign tripped   = r_tripped;
  assign state     = r_state;

endmodule

`default_nettype wire
